// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//
// Lets two requesters share the single-port data SRAM:
//   port 0 = processor data port (lw/sw)
//   port 1 = loader/debug port (preload/dump, optionally locked bursts)
//
// Arbitration is round-robin between the two ports. When port 1 is granted
// with lock1=1, the arbiter stays with port 1 until lock1 drops. The SRAM
// command (CEN/WEN/A/D) is registered, and read data returns two cycles
// after the grant.
//
// Optional feature macro: DMEM_ARB_PERF_CNT_EN
//   When it is defined, the arbiter adds a saturating conflict counter port.
//
// Parameters:
//   AW     SRAM word address width
//   DW     data width
//   CNT_W  conflict counter width (only used with DMEM_ARB_PERF_CNT_EN)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req0/1, we0/1         request and write flag for each port
//   addr0/1, wdata0/1     command address and write data for each port
//   lock1                 port 1 keeps ownership after its grant while high
//   gnt0/1                combinational grant (command accepted this cycle)
//   rvalid0/1, rdata      read response; rdata is shared by both ports
//   stall0                processor freeze (req0 waiting for a grant)
//   CEN/WEN/OEN/A/D/Q     SRAM macro interface (strobes are active-low)
//   conflict_cnt          contention cycles (only with DMEM_ARB_PERF_CNT_EN)

module dmem_port_arbiter #(
  parameter int AW    = 7,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          stall0,
  output logic          CEN,
  output logic          WEN,
  output logic          OEN,
  output logic [AW-1:0] A,
  output logic [DW-1:0] D,
  input  logic [DW-1:0] Q
`ifdef DMEM_ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_LOCK1 = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic   rr_ptr;       // 0: port 0 wins the next contended cycle
  logic   rr_toggle;
  logic   rd_pend0;
  logic   rd_pend1;

  // Grant and next-state logic. While rst_n is low, grants are forced off
  // so that nothing can reach the command register or leave stall0 high.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    rr_toggle  = 1'b0;
    state_next = state;
    if (rst_n) begin
      case (state)
        ST_ARB: begin
          if (req0 && req1) begin
            rr_toggle = 1'b1;
            if (rr_ptr) gnt1 = 1'b1;
            else        gnt0 = 1'b1;
          end else if (req0) begin
            gnt0 = 1'b1;
          end else if (req1) begin
            gnt1 = 1'b1;
          end
          if (gnt1 && lock1) state_next = ST_LOCK1;
        end
        ST_LOCK1: begin
          gnt1 = req1;
          if (!lock1) state_next = ST_ARB;
        end
        default: state_next = ST_ARB;
      endcase
    end
  end

  // The FSM state and round-robin pointer. The pointer only moves on
  // contended grants in ARB, so a locked burst cannot skew fairness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_ARB;
      rr_ptr <= 1'b0;
    end else begin
      state <= state_next;
      if (rr_toggle) rr_ptr <= ~rr_ptr;
    end
  end

  // SRAM command stage. A and D hold their last value when the cycle is
  // idle; CEN=1 is enough to keep the macro quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CEN <= 1'b1;
      WEN <= 1'b1;
      A   <= '0;
      D   <= '0;
    end else if (gnt0) begin
      CEN <= 1'b0;
      WEN <= ~we0;
      A   <= addr0;
      D   <= wdata0;
    end else if (gnt1) begin
      CEN <= 1'b0;
      WEN <= ~we1;
      A   <= addr1;
      D   <= wdata1;
    end else begin
      CEN <= 1'b1;
      WEN <= 1'b1;
    end
  end

  // Read response tracking. The first stage follows the command register,
  // and the second stage lines up with Q after the SRAM has sampled the
  // command. A reset drops any read that is still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend0 <= 1'b0;
      rd_pend1 <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      rd_pend0 <= gnt0 & ~we0;
      rd_pend1 <= gnt1 & ~we1;
      rvalid0  <= rd_pend0;
      rvalid1  <= rd_pend1;
    end
  end

  assign OEN    = 1'b0;
  assign rdata  = (rvalid0 | rvalid1) ? Q : '0;
  assign stall0 = rst_n & req0 & ~gnt0;

`ifdef DMEM_ARB_PERF_CNT_EN
  // Counts cycles in which both ports want the SRAM and exactly one of them
  // gets it. This includes port 0 being denied during a lock. The counter
  // saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (req0 && req1 && (gnt0 ^ gnt1) && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//
// Directed bench for dmem_port_arbiter. A cycle table drives single read,
// write/readback, contention and lock scenarios. Separate sequences cover
// reset during a read, round-robin after reset and, when
// DMEM_ARB_PERF_CNT_EN is defined, the saturating conflict counter.
// A behavioural single-port SRAM with a registered Q sits on the macro side.

module tb_dmem_port_arbiter;

  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int CNT_W = 3;

  localparam logic [AW-1:0] A5  = 7'h05;
  localparam logic [AW-1:0] A10 = 7'h10;
  localparam logic [DW-1:0] DB  = 32'hDEAD_BEEF;
  localparam logic [DW-1:0] WV  = 32'h1234_5678;

  logic          clk;
  logic          rst_n;
  logic          req0, req1, we0, we1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, stall0;
  logic [DW-1:0] rdata;
  logic          CEN, WEN, OEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;
`ifdef DMEM_ARB_PERF_CNT_EN
  logic [CNT_W-1:0] conflict_cnt;
`endif

  int vec_count   = 0;
  int miscompares = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  dmem_port_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .we0     (we0),
    .we1     (we1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .lock1   (lock1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1),
    .rdata   (rdata),
    .stall0  (stall0),
    .CEN     (CEN),
    .WEN     (WEN),
    .OEN     (OEN),
    .A       (A),
    .D       (D),
    .Q       (Q)
`ifdef DMEM_ARB_PERF_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM model: it samples the command on the rising edge and
  // presents read data on Q during the following cycle.
  always @(posedge clk) begin
    if (!CEN) begin
      if (!WEN) mem[A] <= D;
      else      Q <= mem[A];
    end
  end

  typedef struct {
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          lock1;
    logic          gnt0;
    logic          gnt1;
    logic          stall0;
    logic          cen;
    logic          wen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t makeVec(
    input logic i_req0, input logic i_we0, input logic [AW-1:0] i_addr0,
    input logic i_req1, input logic i_we1, input logic [AW-1:0] i_addr1,
    input logic [DW-1:0] i_wdata1, input logic i_lock1,
    input logic e_gnt0, input logic e_gnt1, input logic e_stall0,
    input logic e_cen, input logic e_wen, input logic [AW-1:0] e_a,
    input logic [DW-1:0] e_d, input logic e_rv0, input logic e_rv1,
    input logic [DW-1:0] e_rdata);
    vec_t v;
    v.req0 = i_req0;  v.we0 = i_we0;  v.addr0 = i_addr0;
    v.req1 = i_req1;  v.we1 = i_we1;  v.addr1 = i_addr1;
    v.wdata1 = i_wdata1;  v.lock1 = i_lock1;
    v.gnt0 = e_gnt0;  v.gnt1 = e_gnt1;  v.stall0 = e_stall0;
    v.cen = e_cen;  v.wen = e_wen;  v.a = e_a;  v.d = e_d;
    v.rvalid0 = e_rv0;  v.rvalid1 = e_rv1;  v.rdata = e_rdata;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    req0   = v.req0;
    we0    = v.we0;
    addr0  = v.addr0;
    wdata0 = '0;
    req1   = v.req1;
    we1    = v.we1;
    addr1  = v.addr1;
    wdata1 = v.wdata1;
    lock1  = v.lock1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    lock1 = 1'b0;
  endtask

  task automatic checkVec(input int i, input vec_t v);
    checkOutput($sformatf("row%0d_gnt0", i),    32'(gnt0),    32'(v.gnt0));
    checkOutput($sformatf("row%0d_gnt1", i),    32'(gnt1),    32'(v.gnt1));
    checkOutput($sformatf("row%0d_stall0", i),  32'(stall0),  32'(v.stall0));
    checkOutput($sformatf("row%0d_CEN", i),     32'(CEN),     32'(v.cen));
    checkOutput($sformatf("row%0d_WEN", i),     32'(WEN),     32'(v.wen));
    checkOutput($sformatf("row%0d_A", i),       32'(A),       32'(v.a));
    checkOutput($sformatf("row%0d_D", i),       32'(D),       32'(v.d));
    checkOutput($sformatf("row%0d_rvalid0", i), 32'(rvalid0), 32'(v.rvalid0));
    checkOutput($sformatf("row%0d_rvalid1", i), 32'(rvalid1), 32'(v.rvalid1));
    checkOutput($sformatf("row%0d_rdata", i),   32'(rdata),   32'(v.rdata));
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[5] = DB;
    Q = '0;

    // Idle after reset.
    vecs.push_back(makeVec(0,0,0,   0,0,0,0,    0,  0,0,0, 1,1,0,0,   0,0,0));
    // Single read from port 0 at address 5.
    vecs.push_back(makeVec(1,0,A5,  0,0,0,0,    0,  1,0,0, 1,1,0,0,   0,0,0));
    vecs.push_back(makeVec(0,0,0,   0,0,0,0,    0,  0,0,0, 0,1,A5,0,  0,0,0));
    vecs.push_back(makeVec(0,0,0,   0,0,0,0,    0,  0,0,0, 1,1,A5,0,  1,0,DB));
    vecs.push_back(makeVec(0,0,0,   0,0,0,0,    0,  0,0,0, 1,1,A5,0,  0,0,0));
    // Port 1 writes to 0x10 and then reads it back.
    vecs.push_back(makeVec(0,0,0,   1,1,A10,WV, 0,  0,1,0, 1,1,A5,0,  0,0,0));
    vecs.push_back(makeVec(0,0,0,   1,0,A10,0,  0,  0,1,0, 0,0,A10,WV,0,0,0));
    vecs.push_back(makeVec(0,0,0,   0,0,0,0,    0,  0,0,0, 0,1,A10,0, 0,0,0));
    vecs.push_back(makeVec(0,0,0,   0,0,0,0,    0,  0,0,0, 1,1,A10,0, 0,1,WV));
    vecs.push_back(makeVec(0,0,0,   0,0,0,0,    0,  0,0,0, 1,1,A10,0, 0,0,0));
    // Contention for 4 cycles; the pointer is still 0 after reset.
    vecs.push_back(makeVec(1,0,A5,  1,0,A10,0,  0,  1,0,0, 1,1,A10,0, 0,0,0));
    vecs.push_back(makeVec(1,0,A5,  1,0,A10,0,  0,  0,1,1, 0,1,A5,0,  0,0,0));
    vecs.push_back(makeVec(1,0,A5,  1,0,A10,0,  0,  1,0,0, 0,1,A10,0, 1,0,DB));
    vecs.push_back(makeVec(1,0,A5,  1,0,A10,0,  0,  0,1,1, 0,1,A5,0,  0,1,WV));
    vecs.push_back(makeVec(0,0,0,   0,0,0,0,    0,  0,0,0, 0,1,A10,0, 1,0,DB));
    vecs.push_back(makeVec(0,0,0,   0,0,0,0,    0,  0,0,0, 1,1,A10,0, 0,1,WV));
    vecs.push_back(makeVec(0,0,0,   0,0,0,0,    0,  0,0,0, 1,1,A10,0, 0,0,0));
    // Lock: port 1 enters LOCK1, then port 0 is held off until lock1 drops.
    vecs.push_back(makeVec(0,0,0,   1,0,A10,0,  1,  0,1,0, 1,1,A10,0, 0,0,0));
    vecs.push_back(makeVec(1,0,A5,  1,0,A10,0,  1,  0,1,1, 0,1,A10,0, 0,0,0));
    vecs.push_back(makeVec(1,0,A5,  1,0,A10,0,  1,  0,1,1, 0,1,A10,0, 0,1,WV));
    vecs.push_back(makeVec(1,0,A5,  1,0,A10,0,  1,  0,1,1, 0,1,A10,0, 0,1,WV));
    // lock1 drops. This cycle is still LOCK1, so port 0 stays stalled.
    vecs.push_back(makeVec(1,0,A5,  0,0,0,0,    0,  0,0,1, 0,1,A10,0, 0,1,WV));
    // Back in ARB. The pointer did not move during the lock, so port 0 wins.
    vecs.push_back(makeVec(1,0,A5,  1,0,A10,0,  0,  1,0,0, 1,1,A10,0, 0,1,WV));
    vecs.push_back(makeVec(0,0,0,   0,0,0,0,    0,  0,0,0, 0,1,A5,0,  0,0,0));
    vecs.push_back(makeVec(0,0,0,   0,0,0,0,    0,  0,0,0, 1,1,A5,0,  1,0,DB));
    vecs.push_back(makeVec(0,0,0,   0,0,0,0,    0,  0,0,0, 1,1,A5,0,  0,0,0));

    // Reset values, with both requests active to show the forced-low outputs.
    idleInputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    #1;
    checkOutput("rst_CEN",    32'(CEN),     32'd1);
    checkOutput("rst_WEN",    32'(WEN),     32'd1);
    checkOutput("rst_OEN",    32'(OEN),     32'd0);
    checkOutput("rst_A",      32'(A),       32'd0);
    checkOutput("rst_D",      32'(D),       32'd0);
    checkOutput("rst_gnt0",   32'(gnt0),    32'd0);
    checkOutput("rst_gnt1",   32'(gnt1),    32'd0);
    checkOutput("rst_stall0", 32'(stall0),  32'd0);
    checkOutput("rst_rvalid0",32'(rvalid0), 32'd0);
    checkOutput("rst_rvalid1",32'(rvalid1), 32'd0);
    checkOutput("rst_rdata",  rdata,        32'd0);
`ifdef DMEM_ARB_PERF_CNT_EN
    checkOutput("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
`endif
    idleInputs();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Cycle table.
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1 applyStimulus(vecs[i]);
      #3 checkVec(i, vecs[i]);
    end

    // Reset while a port 0 read is in flight.
    @(posedge clk);
    #1 idleInputs();
    req0 = 1'b1; we0 = 1'b0; addr0 = A5;
    #3 checkOutput("mid_gnt0", 32'(gnt0), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_CEN",    32'(CEN),     32'd1);
    checkOutput("mid_rst_gnt0",   32'(gnt0),    32'd0);
    checkOutput("mid_rst_stall0", 32'(stall0),  32'd0);
    checkOutput("mid_rst_rvalid0",32'(rvalid0), 32'd0);
    @(posedge clk);
    #1 checkOutput("mid_rst_rvalid0_b", 32'(rvalid0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 1'b0;
    @(posedge clk);
    #1 req1 = 1'b1; we1 = 1'b0; addr1 = A10;
    #3 checkOutput("post_rst_gnt1", 32'(gnt1), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1 req1 = 1'b0;
      #3;
      checkOutput($sformatf("post_rst_rvalid0_%0d", k), 32'(rvalid0), 32'd0);
      checkOutput($sformatf("post_rst_rvalid1_%0d", k), 32'(rvalid1),
                  (k == 2) ? 32'd1 : 32'd0);
    end

    // Round-robin after reset: 0,1,0,1 with stall0 in the 2nd and 4th cycles.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 req0 = 1'b1; we0 = 1'b0; addr0 = A5;
      req1 = 1'b1; we1 = 1'b0; addr1 = A10;
      #3;
      checkOutput($sformatf("rr_gnt0_%0d", k),   32'(gnt0),   (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr_gnt1_%0d", k),   32'(gnt1),   (k % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr_stall0_%0d", k), 32'(stall0), (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1 idleInputs();
`ifdef DMEM_ARB_PERF_CNT_EN
    #3 checkOutput("cnt_after_4", 32'(conflict_cnt), 32'd4);
    // Five more contended cycles would exceed 7, so the counter must stop there.
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 req0 = 1'b1; req1 = 1'b1;
    end
    @(posedge clk);
    #1 idleInputs();
    #3 checkOutput("cnt_saturated", 32'(conflict_cnt), 32'd7);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1 req0 = 1'b1; req1 = 1'b1;
    end
    @(posedge clk);
    #1 idleInputs();
    #3 checkOutput("cnt_stays_max", 32'(conflict_cnt), 32'd7);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
